// File: rtl/mem_dump_tx_pkg.sv
// mem_dump_tx_pkg
//   Shared definitions for the data-memory dump transmitter:
//   byte width, FSM state encoding, and default parameters.
//   The defaults match the data memory of the MIPS pipeline:
//   32-bit words and 32 words.
package mem_dump_tx_pkg;

  localparam int BYTE_SIZE             = 8;
  localparam int DEFAULT_IO_BUS_SIZE   = 32;
  localparam int DEFAULT_MEM_ADDR_SIZE = 5;

  typedef enum logic [1:0] {
    MEM_DUMP_IDLE = 2'd0,
    MEM_DUMP_SEND = 2'd1,
    MEM_DUMP_DONE = 2'd2
  } mem_dump_state_e;

endpackage

// File: rtl/mem_dump_tx.sv
// mem_dump_tx
//   Debug-side reader for the data memory. A start request in IDLE
//   snapshots the flat memory debug bus. The block then streams every
//   word over a valid/ready byte interface, most-significant byte first.
//   This interface feeds the debug UART transmitter.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      synchronous, active-low reset
//   i_start      dump request, honoured only in IDLE
//   i_bus_debug  flat memory image; word k at [k*IO_BUS_SIZE +: IO_BUS_SIZE]
//   i_tx_ready   transmitter accepts a byte this cycle
//   o_tx_data    current byte (registered)
//   o_tx_valid   o_tx_data is valid
//   o_busy       high through SEND and DONE
//   o_done       one-cycle pulse after the final byte is accepted
//   o_word_idx   index of the word being sent
//
// Handshake: a byte transfers on every rising edge where o_tx_valid and
// i_tx_ready are both high. While o_tx_valid is high, o_tx_data and
// o_word_idx stay stable until that transfer. o_tx_valid never drops
// before the byte has been taken.
module mem_dump_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int IO_BUS_SIZE   = DEFAULT_IO_BUS_SIZE,
  parameter int MEM_ADDR_SIZE = DEFAULT_MEM_ADDR_SIZE
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic                                        i_start,
  input  logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0]   i_bus_debug,
  input  logic                                        i_tx_ready,
  output logic [BYTE_SIZE-1:0]                        o_tx_data,
  output logic                                        o_tx_valid,
  output logic                                        o_busy,
  output logic                                        o_done,
  output logic [MEM_ADDR_SIZE-1:0]                    o_word_idx
);

  localparam int WORD_COUNT     = 2**MEM_ADDR_SIZE;
  localparam int BYTES_PER_WORD = IO_BUS_SIZE / BYTE_SIZE;
  localparam int BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int BUS_W          = WORD_COUNT * IO_BUS_SIZE;
  localparam int OFF_W          = $clog2(BUS_W);

  // Bit offset of byte 'b' of word 'w' in the flat image. Byte 0 is the
  // most significant byte of the word.
  function automatic logic [OFF_W-1:0] byte_offset(
    input logic [MEM_ADDR_SIZE-1:0] w,
    input logic [BYTE_CNT_W-1:0]    b
  );
    int off;
    off = int'(w) * IO_BUS_SIZE + (BYTES_PER_WORD - 1 - int'(b)) * BYTE_SIZE;
    return OFF_W'(off);
  endfunction

  mem_dump_state_e              state_q,    state_d;
  logic [BUS_W-1:0]             snap_q,     snap_d;
  logic [MEM_ADDR_SIZE-1:0]     word_q,     word_d;
  logic [BYTE_CNT_W-1:0]        byte_q,     byte_d;
  logic [BYTE_SIZE-1:0]         tx_data_q,  tx_data_d;
  logic                         tx_valid_q, tx_valid_d;
  logic                         busy_q,     busy_d;
  logic                         done_q,     done_d;

  logic                         last_byte;
  logic                         last_word;
  logic [MEM_ADDR_SIZE-1:0]     word_nxt;
  logic [BYTE_CNT_W-1:0]        byte_nxt;

  always_comb begin
    last_byte = (byte_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    last_word = (word_q == {MEM_ADDR_SIZE{1'b1}});
    if (last_byte) begin
      byte_nxt = '0;
      word_nxt = word_q + MEM_ADDR_SIZE'(1);
    end else begin
      byte_nxt = byte_q + BYTE_CNT_W'(1);
      word_nxt = word_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    word_d     = word_q;
    byte_d     = byte_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      MEM_DUMP_IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (i_start) begin
          // The first byte comes straight from the bus. The snapshot is
          // loaded on the same edge, so the byte matches the snapshot.
          snap_d     = i_bus_debug;
          word_d     = '0;
          byte_d     = '0;
          tx_data_d  = i_bus_debug[byte_offset('0, '0) +: BYTE_SIZE];
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = MEM_DUMP_SEND;
        end
      end

      MEM_DUMP_SEND: begin
        if (i_tx_ready) begin
          if (last_byte && last_word) begin
            // Hold word_idx on the final word instead of wrapping it.
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = MEM_DUMP_DONE;
          end else begin
            word_d    = word_nxt;
            byte_d    = byte_nxt;
            tx_data_d = snap_q[byte_offset(word_nxt, byte_nxt) +: BYTE_SIZE];
          end
        end
      end

      MEM_DUMP_DONE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = MEM_DUMP_IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = MEM_DUMP_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= MEM_DUMP_IDLE;
      snap_q     <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_word_idx = word_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx
//   Self-checking bench for mem_dump_tx. It applies a table of
//   single-cycle vectors, then runs hand-written multi-cycle sequences.
//   The sequences cover full dumps, backpressure, snapshot isolation,
//   start while busy, reset mid-dump, and back-to-back dumps.
module tb_mem_dump_tx;

  localparam int IO_BUS_SIZE   = 32;
  localparam int MEM_ADDR_SIZE = 5;
  localparam int WORDS         = 2**MEM_ADDR_SIZE;
  localparam int BPW           = IO_BUS_SIZE / 8;
  localparam int BUS_W         = WORDS * IO_BUS_SIZE;
  localparam int TOTAL_BYTES   = WORDS * BPW;

  // ---------------- clock / reset / DUT ----------------
  logic                      i_clk;
  logic                      i_reset;
  logic                      i_start;
  logic [BUS_W-1:0]          i_bus_debug;
  logic                      i_tx_ready;
  logic [7:0]                o_tx_data;
  logic                      o_tx_valid;
  logic                      o_busy;
  logic                      o_done;
  logic [MEM_ADDR_SIZE-1:0]  o_word_idx;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  mem_dump_tx #(
    .IO_BUS_SIZE   (IO_BUS_SIZE),
    .MEM_ADDR_SIZE (MEM_ADDR_SIZE)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_bus_debug (i_bus_debug),
    .i_tx_ready  (i_tx_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_word_idx  (o_word_idx)
  );

  // ---------------- scoreboard state ----------------
  logic [IO_BUS_SIZE-1:0] mem_img [WORDS];
  logic [7:0]             exp_q[$];
  int                     checks = 0;
  int                     errors = 0;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_idx;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs [13];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pack_bus();
    for (int k = 0; k < WORDS; k++) i_bus_debug[k*IO_BUS_SIZE +: IO_BUS_SIZE] = mem_img[k];
  endtask

  task automatic load_pattern();
    for (int k = 0; k < WORDS; k++) mem_img[k] = 32'hA0B0_C000 | 32'(k);
    pack_bus();
  endtask

  // One complete dump. Expected bytes come from mem_img as it stands at
  // start time.
  //   ready_pct      percentage of cycles with i_tx_ready high
  //   scramble       overwrite the bus with all ones right after start
  //   start_pulse_at cycle number on which i_start pulses mid-dump (0 = none)
  //   start_in_done  raise i_start during the DONE cycle
  task automatic run_dump(input int ready_pct, input bit scramble, input int start_pulse_at,
                          input bit start_in_done, output int done_cycle);
    int         cyc;
    int         n_bytes;
    int         busy_cnt;
    bit         done_seen;
    bit         stalled;
    logic [7:0] held_data;
    logic [4:0] held_idx;

    exp_q.delete();
    for (int w = 0; w < WORDS; w++)
      for (int b = 0; b < BPW; b++)
        exp_q.push_back(mem_img[w][(BPW-1-b)*8 +: 8]);

    i_start    = 1'b1;
    i_tx_ready = ($urandom_range(0, 99) < ready_pct);
    step();
    i_start = 1'b0;
    if (scramble) i_bus_debug = '1;

    cyc        = 1;
    n_bytes    = 0;
    busy_cnt   = 0;
    done_seen  = 1'b0;
    stalled    = 1'b0;
    done_cycle = 0;
    held_data  = '0;
    held_idx   = '0;

    while (cyc <= 2000 && !done_seen) begin
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_seen  = 1'b1;
        done_cycle = cyc;
        check("done_valid_low", 32'(o_tx_valid), 32'd0);
        check("done_byte_count", n_bytes, TOTAL_BYTES);
        i_start = start_in_done;
      end else begin
        check("send_valid", 32'(o_tx_valid), 32'd1);
        if (stalled) begin
          check("stall_data", 32'(o_tx_data), 32'(held_data));
          check("stall_idx", 32'(o_word_idx), 32'(held_idx));
        end
        i_start    = (cyc == start_pulse_at);
        i_tx_ready = ($urandom_range(0, 99) < ready_pct);
        if (i_tx_ready && o_tx_valid) begin
          if (exp_q.size() > 0) check("stream_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
          else check("extra_byte", 32'd1, 32'd0);
          check("stream_word_idx", 32'(o_word_idx), n_bytes / BPW);
          n_bytes++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = o_tx_data;
          held_idx  = o_word_idx;
        end
      end
      step();
      cyc++;
    end

    check("done_seen", 32'(done_seen), 32'd1);
    check("queue_empty", exp_q.size(), 0);
    check("busy_cycles", busy_cnt, done_cycle);
    // Now in the cycle after DONE: IDLE, even if i_start was high in DONE.
    check("post_done_valid", 32'(o_tx_valid), 32'd0);
    check("post_done_busy", 32'(o_busy), 32'd0);
    check("post_done_pulse", 32'(o_done), 32'd0);
    i_start    = 1'b0;
    i_tx_ready = 1'b0;
    if (scramble) pack_bus();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dc;
    int idle_activity;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 5'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 5'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 5'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hC0, 5'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hC0, 5'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 5'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hB0, 5'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hB0, 5'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    // Reset for two cycles.
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_tx_ready = 1'b0;
    load_pattern();
    step();
    step();
    check("rst_valid", 32'(o_tx_valid), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_word_idx", 32'(o_word_idx), 32'd0);

    // Idle with no start: nothing may move.
    i_reset       = 1'b1;
    idle_activity = 0;
    for (int i = 0; i < 20; i++) begin
      i_tx_ready = 1'($urandom_range(0, 1));
      step();
      if (o_tx_valid || o_busy || o_done || o_tx_data != 8'h00 || o_word_idx != '0) idle_activity++;
    end
    check("idle_quiet", idle_activity, 0);
    i_tx_ready = 1'b0;

    // Table of single-cycle vectors: start, stalls, word step, ignored
    // start, reset mid-dump.
    for (int v = 0; v < 13; v++) begin
      i_reset    = vecs[v].rst_n;
      i_start    = vecs[v].start;
      i_tx_ready = vecs[v].ready;
      step();
      check($sformatf("vec%0d_valid", v), 32'(o_tx_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), 32'(o_tx_data), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_idx", v), 32'(o_word_idx), 32'(vecs[v].exp_idx));
      check($sformatf("vec%0d_busy", v), 32'(o_busy), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_done", v), 32'(o_done), 32'(vecs[v].exp_done));
    end
    i_start    = 1'b0;
    i_tx_ready = 1'b0;
    i_reset    = 1'b1;
    step();

    // Full dump at full speed.
    run_dump(100, 1'b0, 0, 1'b0, dc);
    check("full_done_cycle", dc, TOTAL_BYTES + 1);

    // Backpressure, about 30% ready.
    run_dump(30, 1'b0, 0, 1'b0, dc);
    check("bp_slower", 32'(dc > TOTAL_BYTES + 1), 32'd1);

    // Snapshot isolation: the bus goes to all ones after start.
    run_dump(100, 1'b1, 0, 1'b0, dc);
    check("snap_done_cycle", dc, TOTAL_BYTES + 1);

    // Start pulse while byte 10 is on the wire must be ignored.
    run_dump(100, 1'b0, 11, 1'b0, dc);
    check("busy_start_done_cycle", dc, TOTAL_BYTES + 1);

    // Reset asserted while byte 50 is on the wire.
    i_start    = 1'b1;
    i_tx_ready = 1'b1;
    step();
    i_start = 1'b0;
    repeat (50) step();
    check("mid_byte50_data", 32'(o_tx_data), 32'h0000_00C0);
    check("mid_byte50_idx", 32'(o_word_idx), 32'd12);
    i_reset = 1'b0;
    step();
    check("midrst_valid", 32'(o_tx_valid), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_idx", 32'(o_word_idx), 32'd0);
    i_reset = 1'b1;
    step();
    check("midrst_no_done", 32'(o_done), 32'd0);
    check("midrst_still_idle", 32'(o_tx_valid), 32'd0);
    i_tx_ready = 1'b0;
    run_dump(100, 1'b0, 0, 1'b0, dc);
    check("after_rst_done_cycle", dc, TOTAL_BYTES + 1);

    // Back-to-back: start in DONE is ignored, start in the following IDLE
    // begins a full new dump.
    run_dump(100, 1'b0, 0, 1'b1, dc);
    run_dump(100, 1'b0, 0, 1'b0, dc);
    check("b2b_done_cycle", dc, TOTAL_BYTES + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
